// File: rtl/net_link_bridge_if.sv
// net_link_bridge_if: PP<->Net handshake plus TX/RX BRAM port-B bundle for one link direction.
interface net_link_bridge_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              busy_PP2Net_TX;
    logic              msg_stored;
    logic [ADDR_W-1:0] sizeTX_msg;
    logic              busy_Net2PP_TX;
    logic              busy_PP2Net_RX;
    logic              busy_Net2PP_RX;
    logic              msg_accessed;
    logic [ADDR_W-1:0] sizeRX_msg;
    logic              tx_bram_en;
    logic [ADDR_W-1:0] tx_bram_addr;
    logic [DATA_W-1:0] tx_bram_dout;
    logic              rx_bram_en;
    logic              rx_bram_we;
    logic [ADDR_W-1:0] rx_bram_addr;
    logic [DATA_W-1:0] rx_bram_din;
    logic [7:0]        drop_cnt;
    logic [3:0]        state;

    modport master (
        output busy_PP2Net_TX, msg_stored, sizeTX_msg, busy_PP2Net_RX, tx_bram_dout,
        input  busy_Net2PP_TX, busy_Net2PP_RX, msg_accessed, sizeRX_msg,
               tx_bram_en, tx_bram_addr, rx_bram_en, rx_bram_we, rx_bram_addr, rx_bram_din,
               drop_cnt, state
    );

    modport slave (
        input  busy_PP2Net_TX, msg_stored, sizeTX_msg, busy_PP2Net_RX, tx_bram_dout,
        output busy_Net2PP_TX, busy_Net2PP_RX, msg_accessed, sizeRX_msg,
               tx_bram_en, tx_bram_addr, rx_bram_en, rx_bram_we, rx_bram_addr, rx_bram_din,
               drop_cnt, state
    );
endinterface

// File: rtl/net_link_bridge.sv
// net_link_bridge: copies a message from the sender's TX BRAM into the receiver's RX BRAM and notifies it.
module net_link_bridge #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32
) (
    input logic             clk,
    input logic             reset_high,
    net_link_bridge_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        WAIT_RX = 4'd1,
        COPY    = 4'd2,
        DRAIN   = 4'd3,
        NOTIFY  = 4'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] n_q, n_d, addr_q, addr_d, size_rx_q, size_rx_d;
    logic [7:0]        drop_q, drop_d;
    logic [1:0]        dcnt_q, dcnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [ADDR_W-1:0] vaddr_q [READ_LATENCY];
    logic [ADDR_W-1:0] vaddr_d [READ_LATENCY];
    logic              rd, wr, accept;
    logic              unused_busy_tx;

    assign unused_busy_tx = bus.busy_PP2Net_TX;

    always_ff @(posedge clk) begin
        if (reset_high) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? WAIT_RX : IDLE;
            WAIT_RX: state_d = bus.busy_PP2Net_RX ? WAIT_RX : COPY;
            COPY:    state_d = (addr_q == n_q - 1'b1) ? DRAIN : COPY;
            DRAIN:   state_d = (dcnt_q == 2'(READ_LATENCY - 1)) ? NOTIFY : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd        = state_q == COPY;
        accept    = state_q == IDLE && bus.msg_stored && bus.sizeTX_msg != '0;
        n_d       = accept ? bus.sizeTX_msg : n_q;
        addr_d    = (rd && state_d == COPY) ? addr_q + 1'b1 : '0;
        dcnt_d    = state_q == DRAIN ? dcnt_q + 1'b1 : 2'd0;
        drop_d    = (bus.msg_stored && state_q != IDLE && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
        size_rx_d = state_d == NOTIFY ? n_q : size_rx_q;
        vld_d[0]   = rd;
        vaddr_d[0] = addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i]   = vld_q[i-1];
            vaddr_d[i] = vaddr_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_high) begin
            n_q       <= '0;
            addr_q    <= '0;
            size_rx_q <= '0;
            drop_q    <= '0;
            dcnt_q    <= '0;
            vld_q     <= '0;
            for (int i = 0; i < READ_LATENCY; i++) vaddr_q[i] <= '0;
        end else begin
            n_q       <= n_d;
            addr_q    <= addr_d;
            size_rx_q <= size_rx_d;
            drop_q    <= drop_d;
            dcnt_q    <= dcnt_d;
            vld_q     <= vld_d;
            for (int i = 0; i < READ_LATENCY; i++) vaddr_q[i] <= vaddr_d[i];
        end
    end

    // writes trail reads by READ_LATENCY; only COPY/DRAIN may touch either BRAM
    always_comb begin
        wr                 = vld_q[READ_LATENCY-1] && (state_q == COPY || state_q == DRAIN);
        bus.busy_Net2PP_TX = state_q != IDLE;
        bus.busy_Net2PP_RX = state_q == COPY || state_q == DRAIN || state_q == NOTIFY;
        bus.msg_accessed   = state_q == NOTIFY;
        bus.sizeRX_msg     = size_rx_q;
        bus.tx_bram_en     = rd;
        bus.tx_bram_addr   = rd ? addr_q : '0;
        bus.rx_bram_en     = wr;
        bus.rx_bram_we     = wr;
        bus.rx_bram_addr   = wr ? vaddr_q[READ_LATENCY-1] : '0;
        bus.rx_bram_din    = wr ? bus.tx_bram_dout : '0;
        bus.drop_cnt       = drop_q;
        bus.state          = state_q;
    end
endmodule
